// File: rtl/bus_dest_decoder_if.sv
// Request/issue bundle between the control unit and the destination decoder.
// The master drives transfer requests; the slave returns load strobes and status.
interface bus_dest_decoder_if #(
    parameter int NDEST = 25
);
    logic             req_valid;
    logic [4:0]       req_dest;
    logic [31:0]      req_data;
    logic             req_ready;
    logic             hold;
    logic [NDEST-1:0] load_en;
    logic [31:0]      load_data;
    logic             busy;
    logic             err_illegal;
    logic [4:0]       err_code;
    logic             err_clr;

    modport master (
        output req_valid, req_dest, req_data, hold, err_clr,
        input  req_ready, load_en, load_data, busy, err_illegal, err_code
    );

    modport slave (
        input  req_valid, req_dest, req_data, hold, err_clr,
        output req_ready, load_en, load_data, busy, err_illegal, err_code
    );
endinterface

// File: rtl/bus_dest_decoder.sv
// Destination decoder: two-entry request queue feeding a registered one-hot
// load-enable stage, with sticky reporting of illegal destination codes.
module bus_dest_decoder #(
    parameter int DEPTH = 2,
    parameter int NDEST = 25
) (
    input logic              clock,
    input logic              clear,
    bus_dest_decoder_if.slave bus
);
    logic [4:0]       q_dest [DEPTH];
    logic [31:0]      q_data [DEPTH];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic             push;
    logic             pop;
    logic [4:0]       head_dest;
    logic [31:0]      head_data;
    logic             head_legal;
    logic [NDEST-1:0] onehot;
    logic [NDEST-1:0] load_en_q;
    logic [31:0]      load_data_q;
    logic             err_illegal_q;
    logic [4:0]       err_code_q;

    // Ready comes only from the registered count, so there is no path from req_valid.
    assign bus.req_ready = (count < 2'(DEPTH));
    assign push          = bus.req_valid && bus.req_ready;
    assign pop           = (count != 2'd0) && !bus.hold;

    assign head_dest  = q_dest[rd_ptr];
    assign head_data  = q_data[rd_ptr];
    assign head_legal = (head_dest <= 5'(NDEST - 1));
    assign onehot     = {{(NDEST-1){1'b0}}, 1'b1} << head_dest;

    // Storage needs no reset: the pointers and count alone decide what is live.
    always_ff @(posedge clock) begin
        if (push) begin
            q_dest[wr_ptr] <= bus.req_dest;
            q_data[wr_ptr] <= bus.req_data;
        end
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            load_en_q   <= '0;
            load_data_q <= '0;
        end else if (pop && head_legal) begin
            load_en_q   <= onehot;
            load_data_q <= head_data;
        end else begin
            load_en_q   <= '0;
            load_data_q <= '0;
        end
    end

    // A clear on the same edge as an illegal issue wins and that event is lost.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            err_illegal_q <= 1'b0;
            err_code_q    <= 5'd0;
        end else if (bus.err_clr) begin
            err_illegal_q <= 1'b0;
            err_code_q    <= 5'd0;
        end else if (pop && !head_legal) begin
            err_illegal_q <= 1'b1;
            if (!err_illegal_q) err_code_q <= head_dest;
        end
    end

    assign bus.load_en     = load_en_q;
    assign bus.load_data   = load_data_q;
    assign bus.err_illegal = err_illegal_q;
    assign bus.err_code    = err_code_q;
    assign bus.busy        = (count != 2'd0) || (load_en_q != '0);
endmodule

// File: tb/tb_bus_dest_decoder.sv
// Bench for bus_dest_decoder: directed scenarios then random traffic, all
// compared every cycle against a transaction-level queue model.
module tb_bus_dest_decoder;
    typedef struct {
        logic [4:0]  dest;
        logic [31:0] data;
    } xfer_t;

    logic clock;
    logic clear;
    int   n_checks;
    int   n_errors;

    xfer_t       mq[$];
    logic [24:0] exp_en;
    logic [31:0] exp_data;
    logic        exp_flag;
    logic [4:0]  exp_code;

    bus_dest_decoder_if #(.NDEST(25)) bus ();

    bus_dest_decoder #(.DEPTH(2), .NDEST(25)) dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, got, want, $time);
        end
    endtask

    // Model: each edge pops the head if allowed, then appends the request if there was room.
    always @(posedge clock or negedge clear) begin
        if (!clear) begin
            mq.delete();
            exp_en   = '0;
            exp_data = '0;
            exp_flag = 1'b0;
            exp_code = '0;
        end else begin
            xfer_t e;
            logic  had_room;
            logic  bad;
            logic [4:0] bad_code;
            had_room = (mq.size() < 2);
            bad      = 1'b0;
            bad_code = '0;
            exp_en   = '0;
            exp_data = '0;
            if (mq.size() != 0 && !bus.hold) begin
                e = mq.pop_front();
                if (e.dest < 25) begin
                    exp_en   = 25'd1 << e.dest;
                    exp_data = e.data;
                end else begin
                    bad      = 1'b1;
                    bad_code = e.dest;
                end
            end
            if (bus.req_valid && had_room) begin
                e.dest = bus.req_dest;
                e.data = bus.req_data;
                mq.push_back(e);
            end
            if (bus.err_clr) begin
                exp_flag = 1'b0;
                exp_code = '0;
            end else if (bad) begin
                if (!exp_flag) exp_code = bad_code;
                exp_flag = 1'b1;
            end
        end
    end

    always @(negedge clock) begin
        check("load_en", 64'(bus.load_en), 64'(exp_en));
        if (exp_en != '0) check("load_data", 64'(bus.load_data), 64'(exp_data));
        check("req_ready", 64'(bus.req_ready), 64'(mq.size() < 2));
        check("busy", 64'(bus.busy), 64'((mq.size() != 0) || (exp_en != '0)));
        check("err_illegal", 64'(bus.err_illegal), 64'(exp_flag));
        check("err_code", 64'(bus.err_code), 64'(exp_code));
        check("onehot", 64'($countones(bus.load_en) <= 1), 64'(1));
    end

    task automatic step(input logic v, input logic [4:0] d, input logic [31:0] dt,
                        input logic h, input logic ec);
        bus.req_valid = v;
        bus.req_dest  = d;
        bus.req_data  = dt;
        bus.hold      = h;
        bus.err_clr   = ec;
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        clear = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_dest  = '0;
        bus.req_data  = '0;
        bus.hold      = 1'b0;
        bus.err_clr   = 1'b0;
        #1;
        check("rst_load_en", 64'(bus.load_en), 64'(0));
        check("rst_ready", 64'(bus.req_ready), 64'(1));
        check("rst_busy", 64'(bus.busy), 64'(0));
        repeat (3) @(posedge clock);
        #1 clear = 1'b1;

        // Reset with two entries queued
        step(1'b1, 5'd5,  32'h1111_0005, 1'b1, 1'b0);
        step(1'b1, 5'd20, 32'h2222_0014, 1'b1, 1'b0);
        clear = 1'b0;
        #1;
        check("midq_load_en", 64'(bus.load_en), 64'(0));
        check("midq_ready", 64'(bus.req_ready), 64'(1));
        check("midq_busy", 64'(bus.busy), 64'(0));
        step(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        clear = 1'b1;
        idle(5);

        // Single transfer
        step(1'b1, 5'd3, 32'h0000_00A5, 1'b0, 1'b0);
        idle(3);

        // Back-to-back stream
        for (int i = 16; i < 20; i++) step(1'b1, 5'(i), 32'(i * 3), 1'b0, 1'b0);
        idle(3);

        // Full under hold, third request dropped
        step(1'b1, 5'd21, 32'hAAAA_0015, 1'b1, 1'b0);
        step(1'b1, 5'd22, 32'hBBBB_0016, 1'b1, 1'b0);
        step(1'b1, 5'd23, 32'hCCCC_0017, 1'b1, 1'b0);
        idle(4);

        // Illegal codes: first one sticks
        step(1'b1, 5'd27, 32'h0, 1'b0, 1'b0);
        step(1'b1, 5'd30, 32'h0, 1'b0, 1'b0);
        idle(3);
        step(1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
        idle(2);

        // err_clr on the same edge as an illegal issue
        step(1'b1, 5'd26, 32'h0, 1'b1, 1'b0);
        step(1'b0, 5'd0,  32'h0, 1'b0, 1'b1);
        idle(2);

        // Push during pop at count 1
        step(1'b1, 5'd7, 32'h7777_0007, 1'b1, 1'b0);
        step(1'b1, 5'd8, 32'h8888_0008, 1'b0, 1'b0);
        idle(3);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            logic [4:0] d;
            d = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(25, 31)) : 5'($urandom_range(0, 24));
            if ($urandom_range(0, 79) == 0) begin
                clear = 1'b0;
                step(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
                clear = 1'b1;
            end else begin
                step(1'($urandom_range(0, 3) != 0), d, $urandom(),
                     1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 19) == 0));
            end
        end
        idle(4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
